apb4_s_regfile: RTL and testbench
=================================

Name: apb4_s_regfile

Overview:
- Parametrised APB4 completer (slave) register bank; next-generation RTL counterpart to the APB3 master/slave agents.
- Adds over APB3: PSTRB byte-lane writes, PPROT-qualified access, programmable wait states, PSLVERR on decode/permission faults, read-only hardware status registers.
- Sits behind the APB interconnect and exposes NUM_REGS control registers to local logic.

Parameters:
- ADDR_WIDTH, 12: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; legal values 8, 16, 32.
- NUM_REGS, 16: register count; power of two, at least 2.
- RO_MASK, 0: bit i set means register i is read-only and mirrors ro_in slice i.
- PRIV_MASK, 0: bit i set means register i requires PPROT[0]=1 (privileged).
- RESET_VAL, 0: reset value of every read/write register.
- WAIT_W, 4: width of cfg_wait.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PPROT  in  3  protection attributes.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  transfer error.
- cfg_wait  in  WAIT_W  wait cycles inserted per transfer.
- ro_in  in  NUM_REGS*DATA_WIDTH  hardware status for read-only registers.
- reg_q  out  NUM_REGS*DATA_WIDTH  current register contents.
- reg_wr_stb  out  NUM_REGS  one-cycle pulse per committed write.

Behaviour:
- Reset: asynchronous on PRESETn low. FSM enters IDLE. PREADY=0, PSLVERR=0, PRDATA=0, reg_wr_stb=0. Every R/W register loads RESET_VAL. Reset mid-transfer abandons it with no write.
- FSM has three states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE, setup sampled (PSEL=1, PENABLE=0):
  - Latch the transfer attributes and cfg_wait into a counter.
  - Counter == 0: go to DONE.
  - Otherwise: go to WAIT.
- WAIT: counter decrements each cycle; at 1, go to DONE. PREADY is 0 throughout.
- DONE (a single cycle): PREADY=1, with PRDATA and PSLVERR valid. Next state is IDLE. A back-to-back setup in the cycle after DONE is accepted normally.
- Latency: the access phase lasts cfg_wait+1 cycles, so cfg_wait=0 gives a zero-wait transfer.
- Decode:
  - ALIGN = log2(DATA_WIDTH/8).
  - idx = PADDR[ALIGN +: log2(NUM_REGS)].
  - Address bits above idx must be 0.
- Error causes (PSLVERR=1 in DONE):
  - nonzero PADDR[ALIGN-1:0];
  - upper address bits nonzero;
  - write to an RO_MASK register;
  - access to a PRIV_MASK register with PPROT[0]=0;
  - read with PSTRB != 0.
- Errored transfer: no register changes, no strobe, PRDATA=0.
- Write: committed at the DONE clock edge. Only byte lanes with PSTRB[b]=1 update. reg_wr_stb[idx] pulses for one cycle after the commit. PSTRB=0 is a legal no-op write and still pulses the strobe.
- Read data: captured when entering DONE.
  - RO register returns the ro_in slice.
  - R/W register returns the stored value.
  - Outside DONE, PRDATA=0.
- PSEL dropped during WAIT (protocol violation): return to IDLE, no write, PREADY stays 0.
- cfg_wait changes mid-transfer have no effect; the value is sampled at setup only.
- reg_q continuously reflects register contents. RO slices of reg_q are 0.

Decomposition:
- Package apb4_pkg holds:
  - state enum apb4_s_state_e (IDLE/WAIT/DONE);
  - error-cause enum apb4_err_e (NONE, MISALIGN, RANGE, RO_WRITE, PRIV, RD_STRB);
  - functions for the byte-lane count and ALIGN.
- One sub-module, apb4_s_regbank:
  - holds storage, byte-strobe write merge, RO/PRIV masks and read mux;
  - the top keeps the FSM, wait counter and decode.

Test Plan:
- Write idx 2 = 0xDEADBEEF, PSTRB=0xF, cfg_wait=0 → PREADY high in the first access cycle, PSLVERR=0, reg_wr_stb[2] pulses once; read idx 2 returns 0xDEADBEEF.
- Reg 3 = 0x11223344; write 0xAABBCCDD with PSTRB=0x5 → reads back 0x11BB33DD.
- cfg_wait=3, read → PREADY low for exactly 3 access cycles, high on the 4th, PRDATA valid only in that cycle.
- Error cases, each giving PSLVERR=1 with registers unchanged and no strobe:
  - PADDR=0x41 (misaligned);
  - PADDR=0x40 with NUM_REGS=16 (out of range);
  - write to an RO_MASK register;
  - PRIV_MASK register with PPROT=0;
  - read with PSTRB=0x1.
- RO reg 5 with ro_in slice = 0x0000CAFE → read returns 0xCAFE; write to it errors.
- Assert PRESETn low during WAIT of a write → write lost, all registers = RESET_VAL, PREADY=0; the next transfer completes normally.

Source files
------------

// File: rtl/apb4_pkg.sv
// Shared types and width helpers for the APB4 completer register file.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb4_s_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE,
    ERR_RO_WRITE,
    ERR_PRIV,
    ERR_RD_STRB
  } apb4_err_e;

  function automatic int unsigned lane_count(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned align_bits(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb4_s_regbank.sv
// Register storage with byte-lane write merge, RO/PRIV attribute lookup and read mux.
module apb4_s_regbank
  import apb4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] PRIV_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned LANES = lane_count(DATA_WIDTH),
  localparam int unsigned IDX_W = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [LANES-1:0]               wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_ro,
  output logic                           rd_priv,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_en && !RO_MASK[wr_idx]) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_ro   = RO_MASK[rd_idx];
  assign rd_priv = PRIV_MASK[rd_idx];
  assign rd_data = rd_ro ? ro_in[rd_idx*DATA_WIDTH +: DATA_WIDTH] : regs[rd_idx];

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

endmodule

// File: rtl/apb4_s_regfile.sv
// APB4 completer register file: transfer FSM, wait-state counter and address/permission decode.
module apb4_s_regfile
  import apb4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] PRIV_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned WAIT_W = 4
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  input  logic [WAIT_W-1:0]              cfg_wait,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_stb
);

  localparam int unsigned ALIGN = align_bits(DATA_WIDTH);
  localparam int unsigned LANES = lane_count(DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] MIS_MASK = ADDR_WIDTH'((64'd1 << ALIGN) - 64'd1);

  apb4_s_state_e          state;
  logic [WAIT_W-1:0]      cnt;
  logic                   wr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [LANES-1:0]       strb_q;
  apb4_err_e              err_q;

  logic                   setup;
  logic [IDX_W-1:0]       addr_idx;
  logic [IDX_W-1:0]       rd_idx;
  logic [DATA_WIDTH-1:0]  bank_rdata;
  logic                   rd_ro;
  logic                   rd_priv;
  apb4_err_e              dec_err;
  apb4_err_e              cur_err;
  logic                   cur_wr;
  logic                   enter_done;
  logic                   commit;
  logic                   unused_prot;

  assign unused_prot = ^PPROT[2:1];
  assign setup    = PSEL && !PENABLE;
  assign addr_idx = PADDR[ALIGN +: IDX_W];
  // In IDLE the bank is looked up with the live address so a zero-wait transfer
  // can decode and capture read data on the setup edge.
  assign rd_idx   = (state == IDLE) ? addr_idx : idx_q;
  assign commit   = (state == DONE) && wr_q && (err_q == ERR_NONE);

  always_comb begin
    dec_err = ERR_NONE;
    if ((PADDR & MIS_MASK) != '0)                dec_err = ERR_MISALIGN;
    else if ((PADDR >> (ALIGN + IDX_W)) != '0)   dec_err = ERR_RANGE;
    else if (PWRITE && rd_ro)                    dec_err = ERR_RO_WRITE;
    else if (rd_priv && !PPROT[0])               dec_err = ERR_PRIV;
    else if (!PWRITE && (PSTRB != '0))           dec_err = ERR_RD_STRB;
  end

  always_comb begin
    enter_done = 1'b0;
    cur_err    = err_q;
    cur_wr     = wr_q;
    if (state == IDLE) begin
      enter_done = setup && (cfg_wait == '0);
      cur_err    = dec_err;
      cur_wr     = PWRITE;
    end else if (state == WAIT) begin
      enter_done = PSEL && (cnt == WAIT_W'(1));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      err_q      <= ERR_NONE;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      PRDATA     <= '0;
      reg_wr_stb <= '0;
    end else begin
      reg_wr_stb <= '0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      PRDATA     <= '0;
      if (enter_done) begin
        PREADY  <= 1'b1;
        PSLVERR <= (cur_err != ERR_NONE);
        if ((cur_err == ERR_NONE) && !cur_wr) PRDATA <= bank_rdata;
      end
      unique case (state)
        IDLE: begin
          if (setup) begin
            wr_q    <= PWRITE;
            idx_q   <= addr_idx;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            err_q   <= dec_err;
            cnt     <= cfg_wait;
            state   <= (cfg_wait == '0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!PSEL)                     state <= IDLE;
          else if (cnt == WAIT_W'(1))    state <= DONE;
          else                           cnt   <= cnt - WAIT_W'(1);
        end
        DONE: begin
          state <= IDLE;
          if (commit) reg_wr_stb[idx_q] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb4_s_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .PRIV_MASK  (PRIV_MASK),
    .RESET_VAL  (RESET_VAL)
  ) u_bank (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .wr_en   (commit),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q),
    .rd_idx  (rd_idx),
    .rd_data (bank_rdata),
    .rd_ro   (rd_ro),
    .rd_priv (rd_priv),
    .ro_in   (ro_in),
    .reg_q   (reg_q)
  );

endmodule

// File: tb/tb_apb4_s_regfile.sv
// Directed bench for apb4_s_regfile: vector table plus hand sequences for reset, PSEL drop and wait sampling.
module tb_apb4_s_regfile;

  localparam logic [31:0] RST_V = 32'h5A5A_0000;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic         PSEL = 1'b0;
  logic         PENABLE = 1'b0;
  logic         PWRITE = 1'b0;
  logic [11:0]  PADDR = '0;
  logic [31:0]  PWDATA = '0;
  logic [3:0]   PSTRB = '0;
  logic [2:0]   PPROT = '0;
  logic         PREADY;
  logic [31:0]  PRDATA;
  logic         PSLVERR;
  logic [3:0]   cfg_wait = '0;
  logic [511:0] ro_in;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr_stb;

  int checks = 0;
  int errors = 0;

  apb4_s_regfile #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .RO_MASK    (16'h0020),
    .PRIV_MASK  (16'h0080),
    .RESET_VAL  (RST_V),
    .WAIT_W     (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PPROT      (PPROT),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR),
    .cfg_wait   (cfg_wait),
    .ro_in      (ro_in),
    .reg_q      (reg_q),
    .reg_wr_stb (reg_wr_stb)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
    logic [3:0]  wt;
    logic [31:0] erd;
    logic        eerr;
    logic [15:0] estb;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transfer; wt_after changes cfg_wait once the access phase starts.
  task automatic do_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p, input logic [3:0] wt,
                         input logic [3:0] wt_after,
                         output logic [31:0] rd, output logic err, output int lows,
                         output logic leak, output logic [15:0] stb1, output logic [15:0] stb2);
    @(posedge PCLK); #1;
    cfg_wait = wt; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w;
    PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cfg_wait = wt_after;
    lows = 0;
    leak = 1'b0;
    while (!PREADY && lows < 40) begin
      if (PRDATA != '0 || PSLVERR) leak = 1'b1;
      @(posedge PCLK); #1;
      lows++;
    end
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    stb1 = reg_wr_stb;
    if (PRDATA != '0 || PREADY) leak = 1'b1;
    @(posedge PCLK); #1;
    stb2 = reg_wr_stb;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lows;
  logic        leak;
  logic [15:0] stb1, stb2;
  logic        bad;

  initial begin
    for (int i = 0; i < 16; i++) ro_in[i*32 +: 32] = 32'hF0F0_0000 | 32'(i);
    ro_in[5*32 +: 32] = 32'h0000_CAFE;

    //        w     addr     wdata          strb  prot  wt    exp_rdata      err   exp_stb
    vecs[0]  = '{1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 3'd0, 4'd0, 32'h0,        1'b0, 16'h0004};
    vecs[1]  = '{1'b0, 12'h008, 32'h0,        4'h0, 3'd0, 4'd0, 32'hDEADBEEF, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 12'h00C, 32'h11223344, 4'hF, 3'd0, 4'd1, 32'h0,        1'b0, 16'h0008};
    vecs[3]  = '{1'b1, 12'h00C, 32'hAABBCCDD, 4'h5, 3'd0, 4'd0, 32'h0,        1'b0, 16'h0008};
    vecs[4]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 3'd0, 4'd0, 32'h11BB33DD, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 3'd0, 4'd3, 32'h11BB33DD, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 12'h041, 32'h12345678, 4'hF, 3'd0, 4'd0, 32'h0,        1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 12'h040, 32'h12345678, 4'hF, 3'd0, 4'd0, 32'h0,        1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 12'h040, 32'h0,        4'h0, 3'd0, 4'd2, 32'h0,        1'b1, 16'h0000};
    vecs[9]  = '{1'b1, 12'h014, 32'h55555555, 4'hF, 3'd0, 4'd0, 32'h0,        1'b1, 16'h0000};
    vecs[10] = '{1'b0, 12'h014, 32'h0,        4'h0, 3'd0, 4'd0, 32'h0000CAFE, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 12'h01C, 32'h99999999, 4'hF, 3'd0, 4'd0, 32'h0,        1'b1, 16'h0000};
    vecs[12] = '{1'b1, 12'h01C, 32'h12345678, 4'hF, 3'd1, 4'd0, 32'h0,        1'b0, 16'h0080};
    vecs[13] = '{1'b0, 12'h01C, 32'h0,        4'h0, 3'd0, 4'd0, 32'h0,        1'b1, 16'h0000};
    vecs[14] = '{1'b0, 12'h01C, 32'h0,        4'h0, 3'd1, 4'd0, 32'h12345678, 1'b0, 16'h0000};
    vecs[15] = '{1'b0, 12'h008, 32'h0,        4'h1, 3'd0, 4'd0, 32'h0,        1'b1, 16'h0000};
    vecs[16] = '{1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 3'd0, 4'd0, 32'h0,        1'b0, 16'h0010};
    vecs[17] = '{1'b0, 12'h010, 32'h0,        4'h0, 3'd0, 4'd0, RST_V,        1'b0, 16'h0000};
    vecs[18] = '{1'b0, 12'h008, 32'h0,        4'h0, 3'd0, 4'd2, 32'hDEADBEEF, 1'b0, 16'h0000};
    vecs[19] = '{1'b0, 12'h000, 32'h0,        4'h0, 3'd0, 4'd0, RST_V,        1'b0, 16'h0000};

    repeat (3) @(posedge PCLK);
    #1;
    check("reset pready", 64'(PREADY), 64'd0);
    check("reset pslverr", 64'(PSLVERR), 64'd0);
    check("reset prdata", 64'(PRDATA), 64'd0);
    check("reset stb", 64'(reg_wr_stb), 64'd0);
    check("reset reg0", 64'(reg_q[0 +: 32]), 64'(RST_V));
    PRESETn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      do_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].p, vecs[i].wt, vecs[i].wt,
              rd, err, lows, leak, stb1, stb2);
      check($sformatf("v%0d rdata", i), 64'(rd), 64'(vecs[i].erd));
      check($sformatf("v%0d pslverr", i), 64'(err), 64'(vecs[i].eerr));
      check($sformatf("v%0d wait_cycles", i), 64'(lows), 64'(vecs[i].wt));
      check($sformatf("v%0d strobe", i), 64'(stb1), 64'(vecs[i].estb));
      check($sformatf("v%0d strobe_once", i), 64'(stb2), 64'd0);
      check($sformatf("v%0d outside_done", i), 64'(leak), 64'd0);
    end

    check("reg_q 2", 64'(reg_q[2*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
    check("reg_q 3", 64'(reg_q[3*32 +: 32]), 64'h0000_0000_11BB_33DD);
    check("reg_q 5 ro", 64'(reg_q[5*32 +: 32]), 64'd0);
    check("reg_q 7", 64'(reg_q[7*32 +: 32]), 64'h0000_0000_1234_5678);
    check("reg_q 4 noop", 64'(reg_q[4*32 +: 32]), 64'(RST_V));

    // PSEL dropped in WAIT: abandoned, no write, no PREADY.
    @(posedge PCLK); #1;
    cfg_wait = 4'd4; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 12'h000; PWDATA = 32'h0BAD_0BAD; PSTRB = 4'hF; PPROT = 3'd0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge PCLK); #1;
      if (PREADY || reg_wr_stb != '0) bad = 1'b1;
    end
    check("psel_drop no ready/stb", 64'(bad), 64'd0);
    check("psel_drop reg0", 64'(reg_q[0 +: 32]), 64'(RST_V));
    do_xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'd0, 4'd0, 4'd0, rd, err, lows, leak, stb1, stb2);
    check("psel_drop next read", 64'(rd), 64'(RST_V));
    check("psel_drop next lat", 64'(lows), 64'd0);

    // Reset asserted during WAIT of a write.
    @(posedge PCLK); #1;
    cfg_wait = 4'd5; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 12'h008; PWDATA = 32'h0102_0304; PSTRB = 4'hF; PPROT = 3'd0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #2;
    check("midreset pready", 64'(PREADY), 64'd0);
    check("midreset stb", 64'(reg_wr_stb), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (reg_q[i*32 +: 32] !== ((i == 5) ? 32'h0 : RST_V)) bad = 1'b1;
    end
    check("midreset all regs", 64'(bad), 64'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("midreset still idle", 64'(PREADY), 64'd0);
    PRESETn = 1'b1;
    do_xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'd0, 4'd0, 4'd0, rd, err, lows, leak, stb1, stb2);
    check("after reset read", 64'(rd), 64'(RST_V));
    check("after reset err", 64'(err), 64'd0);
    do_xfer(1'b1, 12'h008, 32'hCAFEF00D, 4'hF, 3'd0, 4'd1, 4'd1, rd, err, lows, leak, stb1, stb2);
    check("after reset write stb", 64'(stb1), 64'h0004);
    check("after reset write reg", 64'(reg_q[2*32 +: 32]), 64'h0000_0000_CAFE_F00D);

    // cfg_wait sampled at setup only.
    do_xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'd0, 4'd3, 4'd0, rd, err, lows, leak, stb1, stb2);
    check("wait_sampled cycles", 64'(lows), 64'd3);
    check("wait_sampled rdata", 64'(rd), 64'h0000_0000_CAFE_F00D);
    do_xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'd0, 4'd0, 4'd7, rd, err, lows, leak, stb1, stb2);
    check("wait_sampled zero", 64'(lows), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
